// File: rtl/fft16_out_serializer.sv
// rtl/fft16_out_serializer.sv - 16-point FFT parallel-to-stream output serializer
//
// Purpose:
//    Captures all 16 complex results of the final butterfly stage in one cycle on a
//    load strobe, then emits them one point per accepted beat over a valid/ready stream.
//
// Configuration:
//    FFT_SER_BITREV_EN  when defined, beat k carries buffer point bitrev4(k), which
//                       turns the radix-2 DIT stage order into natural frequency order.
//                       When undefined, beat k carries buffer point k.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    load       1-cycle strobe, data_i_R/data_i_I hold a complete frame
//    data_i_R   packed real parts, point p at [p*DW +: DW]
//    data_i_I   packed imaginary parts, same packing
//    out_valid  out_R/out_I/out_idx/out_last hold a valid beat
//    out_ready  downstream accepts the beat when high together with out_valid
//    out_R      real part of the current beat
//    out_I      imaginary part of the current beat
//    out_idx    output position k (0..15) of the current beat
//    out_last   high with out_valid on k=15
//    busy       a frame is held or being sent
//    drop       1-cycle pulse, a load arrived mid-frame and was rejected

module fft16_out_serializer #(
   parameter int DW  = 17,
   parameter int NPT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [NPT*DW-1:0] data_i_R,
   input  logic [NPT*DW-1:0] data_i_I,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_R,
   output logic [DW-1:0]     out_I,
   output logic [3:0]        out_idx,
   output logic              out_last,
   output logic              busy,
   output logic              drop
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t        state;
   state_t        state_nxt;

   logic [DW-1:0] frame_R [NPT];
   logic [DW-1:0] frame_I [NPT];

   logic          xfer;
   logic          last_xfer;
   logic          accept;
   logic          reject;
   logic [3:0]    k_inc;
   logic [3:0]    pt_first;
   logic [3:0]    pt_next;

   // Buffer point carried by output position k.
   function automatic logic [3:0] map_pt(input logic [3:0] k);
`ifdef FFT_SER_BITREV_EN
      return {k[0], k[1], k[2], k[3]};
`else
      return k;
`endif
   endfunction

   // out_idx doubles as the beat counter k; it only returns to 0 through a reload.
   assign xfer      = (state == SEND) && out_ready;
   assign last_xfer = xfer && (out_idx == 4'd15);
   // A load coinciding with the final transfer is taken so frames can stream without a bubble.
   assign accept    = load && ((state == IDLE) || last_xfer);
   assign reject    = load && (state == SEND) && !last_xfer;
   assign k_inc     = out_idx + 4'd1;
   assign pt_first  = map_pt(4'd0);
   assign pt_next   = map_pt(k_inc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SEND;
         end
         SEND: begin
            if (last_xfer && !accept) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Driven from the state flop only, so out_ready never reaches an output combinationally.
   always_comb begin
      out_valid = 1'b0;
      busy      = 1'b0;
      if (state == SEND) begin
         out_valid = 1'b1;
         busy      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NPT; p++) begin
            frame_R[p] <= '0;
            frame_I[p] <= '0;
         end
         out_R    <= '0;
         out_I    <= '0;
         out_idx  <= '0;
         out_last <= 1'b0;
         drop     <= 1'b0;
      end else begin
         drop <= reject;
         if (accept) begin
            for (int p = 0; p < NPT; p++) begin
               frame_R[p] <= data_i_R[p*DW +: DW];
               frame_I[p] <= data_i_I[p*DW +: DW];
            end
            // The buffer is only written this edge, so beat 0 comes straight from the inputs.
            out_R    <= data_i_R[int'(pt_first)*DW +: DW];
            out_I    <= data_i_I[int'(pt_first)*DW +: DW];
            out_idx  <= 4'd0;
            out_last <= 1'b0;
         end else if (xfer) begin
            if (last_xfer) begin
               out_last <= 1'b0;
            end else begin
               out_R    <= frame_R[pt_next];
               out_I    <= frame_I[pt_next];
               out_idx  <= k_inc;
               out_last <= (k_inc == 4'd15);
            end
         end
      end
   end

endmodule

// File: tb/tb_fft16_out_serializer.sv
// tb/tb_fft16_out_serializer.sv - self-checking bench for fft16_out_serializer

module tb_fft16_out_serializer;

   localparam int DW = 17;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load = 1'b0;
   logic              out_ready = 1'b0;
   logic [16*DW-1:0]  data_R = '0;
   logic [16*DW-1:0]  data_I = '0;
   logic              out_valid;
   logic [DW-1:0]     out_R;
   logic [DW-1:0]     out_I;
   logic [3:0]        out_idx;
   logic              out_last;
   logic              busy;
   logic              drop;

   fft16_out_serializer #(.DW(DW), .NPT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .data_i_R  (data_R),
      .data_i_I  (data_I),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_R     (out_R),
      .out_I     (out_I),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .drop      (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] r;
      logic [DW-1:0] i;
      logic [3:0]    idx;
   } beat_t;

   typedef struct {
      logic          ld;
      logic          rdy;
      logic          e_valid;
      logic [DW-1:0] e_R;
      logic [DW-1:0] e_I;
      logic [3:0]    e_idx;
      logic          e_last;
      logic          e_busy;
   } vec_t;

   beat_t         q[$];
   logic          drop_exp = 1'b0;
   logic [DW-1:0] fr_R [16];
   logic [DW-1:0] fr_I [16];
   vec_t          tbl [17];
   int            ord [16];
   int            n_chk = 0;
   int            n_fail = 0;

   function automatic int rev4(input int k);
      int r = 0;
      for (int b = 0; b < 4; b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   function automatic int point_of(input int k);
`ifdef FFT_SER_BITREV_EN
      return rev4(k);
`else
      return k;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pack_frame();
      for (int p = 0; p < 16; p++) begin
         data_R[p*DW +: DW] = fr_R[p];
         data_I[p*DW +: DW] = fr_I[p];
      end
   endtask

   task automatic rand_frame();
      for (int p = 0; p < 16; p++) begin
         fr_R[p] = DW'($urandom);
         fr_I[p] = DW'($urandom);
      end
   endtask

   task automatic check_outputs();
      logic v;
      v = (q.size() != 0);
      check("out_valid", 32'(out_valid), 32'(v));
      check("busy", 32'(busy), 32'(v));
      check("drop", 32'(drop), 32'(drop_exp));
      if (v) begin
         check("out_R", 32'(out_R), 32'(q[0].r));
         check("out_I", 32'(out_I), 32'(q[0].i));
         check("out_idx", 32'(out_idx), 32'(q[0].idx));
         check("out_last", 32'(out_last), 32'(q[0].idx == 4'd15));
      end
   endtask

   // One clock: apply inputs, advance the queue model, compare after the edge.
   task automatic step(input logic ld, input logic rdy);
      logic valid_now;
      logic last_x;
      load      = ld;
      out_ready = rdy;
      pack_frame();
      valid_now = (q.size() != 0);
      last_x    = 1'b0;
      if (valid_now && rdy) begin
         last_x = (q[0].idx == 4'd15);
         void'(q.pop_front());
      end
      drop_exp = 1'b0;
      if (ld) begin
         if (!valid_now || last_x) begin
            for (int k = 0; k < 16; k++)
               q.push_back('{fr_R[point_of(k)], fr_I[point_of(k)], 4'(k)});
         end else begin
            drop_exp = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      check_outputs();
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && q.size() != 0; c++) step(1'b0, 1'b1);
      step(1'b0, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_R"}, 32'(out_R), 32'd0);
      check({tag, "_I"}, 32'(out_I), 32'd0);
      check({tag, "_idx"}, 32'(out_idx), 32'd0);
      check({tag, "_last"}, 32'(out_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_drop"}, 32'(drop), 32'd0);
   endtask

   initial begin
`ifdef FFT_SER_BITREV_EN
      ord = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
      ord = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
      for (int j = 0; j < 16; j++) begin
         tbl[j].ld      = (j == 0);
         tbl[j].rdy     = 1'b1;
         tbl[j].e_valid = 1'b1;
         tbl[j].e_R     = DW'(ord[j]);
         tbl[j].e_I     = DW'(-ord[j]);
         tbl[j].e_idx   = 4'(j);
         tbl[j].e_last  = (j == 15);
         tbl[j].e_busy  = 1'b1;
      end
      tbl[16] = '{1'b0, 1'b1, 1'b0, '0, '0, 4'd0, 1'b0, 1'b0};

      // Reset state
      #1;
      check_all_zero("rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b1);

      // Basic frame, point p: R=p, I=-p
      for (int p = 0; p < 16; p++) begin
         fr_R[p] = DW'(p);
         fr_I[p] = DW'(-p);
      end
      pack_frame();
      for (int j = 0; j < 17; j++) begin
         load      = tbl[j].ld;
         out_ready = tbl[j].rdy;
         @(posedge clk);
         #1;
         load = 1'b0;
         check($sformatf("tbl%0d_valid", j), 32'(out_valid), 32'(tbl[j].e_valid));
         check($sformatf("tbl%0d_busy", j), 32'(busy), 32'(tbl[j].e_busy));
         check($sformatf("tbl%0d_drop", j), 32'(drop), 32'd0);
         if (tbl[j].e_valid) begin
            check($sformatf("tbl%0d_R", j), 32'(out_R), 32'(tbl[j].e_R));
            check($sformatf("tbl%0d_I", j), 32'(out_I), 32'(tbl[j].e_I));
            check($sformatf("tbl%0d_idx", j), 32'(out_idx), 32'(tbl[j].e_idx));
            check($sformatf("tbl%0d_last", j), 32'(out_last), 32'(tbl[j].e_last));
         end
      end

      // Backpressure: stall 3 cycles at k=5
      rand_frame();
      step(1'b1, 1'b1);
      repeat (5) step(1'b0, 1'b1);
      repeat (3) begin
         step(1'b0, 1'b0);
         check("stall_idx", 32'(out_idx), 32'd5);
         check("stall_R", 32'(out_R), 32'(fr_R[point_of(5)]));
      end
      drain();

      // Drop: second load at k=7 is rejected, first frame continues
      rand_frame();
      step(1'b1, 1'b1);
      repeat (7) step(1'b0, 1'b1);
      check("drop_at_idx", 32'(out_idx), 32'd7);
      rand_frame();
      step(1'b1, 1'b1);
      check("drop_pulse", 32'(drop), 32'd1);
      step(1'b0, 1'b1);
      check("drop_clear", 32'(drop), 32'd0);
      drain();

      // Back-to-back: load on the k=15 transfer
      rand_frame();
      step(1'b1, 1'b1);
      repeat (15) step(1'b0, 1'b1);
      check("b2b_at_last", 32'(out_last), 32'd1);
      rand_frame();
      step(1'b1, 1'b1);
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_idx", 32'(out_idx), 32'd0);
      check("b2b_drop", 32'(drop), 32'd0);
      drain();

      // Extremes
      for (int p = 0; p < 16; p++) begin
         fr_R[p] = 17'h0FFFF;
         fr_I[p] = 17'h10000;
      end
      step(1'b1, 1'b1);
      drain();

      // Reset mid-frame
      rand_frame();
      step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b1);
      out_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      q.delete();
      drop_exp = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) step(1'b0, 1'b1);

      // Random traffic against the queue model
      for (int c = 0; c < 800; c++) begin
         rand_frame();
         step(($urandom % 10) == 0, ($urandom % 4) != 0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
